// File: rtl/ulpi_phy_frontend_if.sv
// ULPI pad-side bus bundle between the PHY pins and the link front-end.
// master: the front-end (drives data/oe/stp, observes dir/nxt/data-in).
// slave : the PHY side of the pins.
interface ulpi_phy_frontend_if;
  logic       ulpi_dir_i;
  logic       ulpi_nxt_i;
  logic [7:0] ulpi_data_in_i;
  logic [7:0] ulpi_data_out_o;
  logic       ulpi_data_oe_o;
  logic       ulpi_stp_o;

  modport master (
    input  ulpi_dir_i,
    input  ulpi_nxt_i,
    input  ulpi_data_in_i,
    output ulpi_data_out_o,
    output ulpi_data_oe_o,
    output ulpi_stp_o
  );

  modport slave (
    output ulpi_dir_i,
    output ulpi_nxt_i,
    output ulpi_data_in_i,
    input  ulpi_data_out_o,
    input  ulpi_data_oe_o,
    input  ulpi_stp_o
  );
endinterface

// File: rtl/ulpi_phy_frontend.sv
// ULPI pad front-end and PHY power-up sequencer.
// Synchronises rst_n, runs a timed PHY-reset / settle / wait-for-DIR-low
// sequence, holds the core in reset until RUN, gates OE/STP outside RUN and
// flags DIR turnaround cycles.
// Optional DIR-stuck watchdog in RUN: define ULPI_FE_DIR_WATCHDOG_EN.
module ulpi_phy_frontend #(
  parameter int RST_SYNC_STAGES    = 4,
  parameter int PHY_RST_CYCLES     = 16,
  parameter int PHY_SETTLE_CYCLES  = 64,
  parameter int PHY_RST_ACTIVE_LOW = 0,
  parameter int DIR_TIMEOUT        = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_n,
  input  logic                       soft_rst_req_i,
  ulpi_phy_frontend_if.master        ulpi,
  output logic                       ulpi_reset_o,
  input  logic [7:0]                 core_data_in_i,
  input  logic                       core_stp_i,
  output logic [7:0]                 core_data_out_o,
  output logic                       core_dir_o,
  output logic                       core_nxt_o,
  output logic                       core_rst_o,
  output logic                       turnaround_o,
  output logic                       ready_o,
  output logic [1:0]                 state_o,
  output logic                       timeout_o
);

  localparam int MAX_A   = (PHY_RST_CYCLES > PHY_SETTLE_CYCLES) ? PHY_RST_CYCLES : PHY_SETTLE_CYCLES;
  localparam int MAX_CYC = (MAX_A > DIR_TIMEOUT) ? MAX_A : DIR_TIMEOUT;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  // Counter holds "cycles remaining in this state minus one".
  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(PHY_SETTLE_CYCLES - 1);
  // After a hard reset the counter comes up at 0, so the first RESET cycle is
  // spent loading it; one cycle less remains at that point.
  localparam logic [CNT_W-1:0] RST_FIRST_LOAD = CNT_W'((PHY_RST_CYCLES >= 2) ? (PHY_RST_CYCLES - 2) : 0);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_WAIT_DIR = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  logic [RST_SYNC_STAGES-1:0] rst_sync_reg;
  logic                       rst_int_n;
  state_t                     state_reg, state_next;
  logic [CNT_W-1:0]           cnt_reg, cnt_next;
  logic                       load_pending_reg, load_pending_next;
  logic                       core_rst_reg, ready_reg;
  logic                       dir_q_reg;
  logic                       wd_trip;
  logic                       in_run;

  // Reset synchroniser: clears at once on rst_n low, releases after the chain fills.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= '0;
    else        rst_sync_reg <= {rst_sync_reg[RST_SYNC_STAGES-2:0], 1'b1};
  end

  assign rst_int_n = rst_sync_reg[RST_SYNC_STAGES-1];

`ifdef ULPI_FE_DIR_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic             timeout_reg;

  assign wd_trip     = (state_reg == ST_RUN) && ulpi.ulpi_dir_i &&
                       (wd_cnt_reg == CNT_W'(DIR_TIMEOUT - 1));
  assign wd_cnt_next = ((state_reg == ST_RUN) && ulpi.ulpi_dir_i && !wd_trip) ?
                       wd_cnt_reg + 1'b1 : '0;

  // Count consecutive DIR-high RUN cycles; register the one-cycle timeout pulse.
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      wd_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      wd_cnt_reg  <= wd_cnt_next;
      timeout_reg <= wd_trip && !soft_rst_req_i;
    end
  end

  assign timeout_o = timeout_reg;
`else
  assign wd_trip   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Sequencer state, counter and registered core-facing status.
  always_ff @(posedge clk_i or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_reg        <= ST_RESET;
      cnt_reg          <= '0;
      load_pending_reg <= 1'b1;
      core_rst_reg     <= 1'b1;
      ready_reg        <= 1'b0;
      dir_q_reg        <= 1'b1;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      load_pending_reg <= load_pending_next;
      // Core leaves reset one cycle after RUN entry, and re-enters reset on
      // the very cycle the sequencer leaves RUN.
      core_rst_reg     <= !((state_reg == ST_RUN) && (state_next == ST_RUN));
      ready_reg        <= (state_reg == ST_RUN) && (state_next == ST_RUN);
      dir_q_reg        <= ulpi.ulpi_dir_i;
    end
  end

  // Next-state and counter reload logic; soft request outranks everything but RESET.
  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg;
    load_pending_next = load_pending_reg;
    if (soft_rst_req_i && (state_reg != ST_RESET)) begin
      state_next = ST_RESET;
      cnt_next   = RST_LOAD;
    end else begin
      case (state_reg)
        ST_RESET: begin
          if (load_pending_reg) begin
            load_pending_next = 1'b0;
            if (PHY_RST_CYCLES <= 1) begin
              state_next = ST_SETTLE;
              cnt_next   = SETTLE_LOAD;
            end else begin
              cnt_next = RST_FIRST_LOAD;
            end
          end else if (cnt_reg == '0) begin
            state_next = ST_SETTLE;
            cnt_next   = SETTLE_LOAD;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_reg == '0) begin
            state_next = ST_WAIT_DIR;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - 1'b1;
          end
        end
        ST_WAIT_DIR: begin
          if (!ulpi.ulpi_dir_i) begin
            state_next = ST_RUN;
            cnt_next   = '0;
          end
        end
        ST_RUN: begin
          if (wd_trip) begin
            state_next = ST_RESET;
            cnt_next   = RST_LOAD;
          end
        end
        default: begin
          state_next = ST_RESET;
          cnt_next   = RST_LOAD;
        end
      endcase
    end
  end

  assign in_run = (state_reg == ST_RUN);

  // Bus release must follow DIR without a register in the path.
  assign ulpi.ulpi_data_oe_o  = in_run & ~ulpi.ulpi_dir_i;
  assign ulpi.ulpi_data_out_o = in_run ? core_data_in_i : 8'h00;
  assign ulpi.ulpi_stp_o      = in_run & core_stp_i;

  assign ulpi_reset_o    = (PHY_RST_ACTIVE_LOW != 0) ? (state_reg != ST_RESET) : (state_reg == ST_RESET);

  assign core_data_out_o = ulpi.ulpi_data_in_i;
  assign core_dir_o      = ulpi.ulpi_dir_i;
  assign core_nxt_o      = ulpi.ulpi_nxt_i;
  assign core_rst_o      = core_rst_reg;
  assign ready_o         = ready_reg;
  assign state_o         = state_reg;
  assign turnaround_o    = rst_int_n & (ulpi.ulpi_dir_i ^ dir_q_reg);

endmodule

// File: tb/tb_ulpi_phy_frontend.sv
// Directed bench for ulpi_phy_frontend: power-up timing, WAIT_DIR hold,
// RUN-mode bus vectors, soft re-sequence, async reset and DIR watchdog.
module tb_ulpi_phy_frontend;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       soft_rst_req_i = 1'b0;
  logic       ulpi_reset_o;
  logic [7:0] core_data_in_i = 8'h00;
  logic       core_stp_i = 1'b0;
  logic [7:0] core_data_out_o;
  logic       core_dir_o, core_nxt_o, core_rst_o, turnaround_o, ready_o, timeout_o;
  logic [1:0] state_o;

  int n_vec = 0;
  int n_err = 0;

  ulpi_phy_frontend_if ulpi_if ();

  ulpi_phy_frontend #(
    .RST_SYNC_STAGES   (4),
    .PHY_RST_CYCLES    (16),
    .PHY_SETTLE_CYCLES (64),
    .PHY_RST_ACTIVE_LOW(0),
    .DIR_TIMEOUT       (8)
  ) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .soft_rst_req_i (soft_rst_req_i),
    .ulpi           (ulpi_if),
    .ulpi_reset_o   (ulpi_reset_o),
    .core_data_in_i (core_data_in_i),
    .core_stp_i     (core_stp_i),
    .core_data_out_o(core_data_out_o),
    .core_dir_o     (core_dir_o),
    .core_nxt_o     (core_nxt_o),
    .core_rst_o     (core_rst_o),
    .turnaround_o   (turnaround_o),
    .ready_o        (ready_o),
    .state_o        (state_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       dir;
    logic       nxt;
    logic [7:0] din;
    logic [7:0] cdat;
    logic       cstp;
    logic [7:0] e_out;
    logic       e_oe;
    logic       e_stp;
    logic       e_ta;
  } vec_t;

  vec_t vtab [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Release rst_n just after an edge and check the whole power-up timeline (DIR held 0).
  task automatic powerup_seq(input string tag);
    logic [1:0] e_state;
    rst_n = 1'b1;
    for (int c = 1; c <= 87; c++) begin
      tick();
      if (c < 20)       e_state = 2'd0;
      else if (c < 84)  e_state = 2'd1;
      else if (c == 84) e_state = 2'd2;
      else              e_state = 2'd3;
      chk($sformatf("%s state c%0d", tag, c), 32'(state_o), 32'(e_state));
      chk($sformatf("%s phy_rst c%0d", tag, c), 32'(ulpi_reset_o), 32'(c < 20));
      chk($sformatf("%s core_rst c%0d", tag, c), 32'(core_rst_o), 32'(c < 86));
      chk($sformatf("%s ready c%0d", tag, c), 32'(ready_o), 32'(c >= 86));
      chk($sformatf("%s oe c%0d", tag, c), 32'(ulpi_if.ulpi_data_oe_o), 32'(c >= 85));
      if (c >= 3 && c <= 5)
        chk($sformatf("%s turnaround c%0d", tag, c), 32'(turnaround_o), 32'(c == 4));
    end
  endtask

  initial begin
    //             dir  nxt   din    cdat   stp   e_out  oe    stp   ta
    vtab[0] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0};
    vtab[1] = '{1'b1, 1'b0, 8'h00, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b1};
    vtab[2] = '{1'b1, 1'b1, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vtab[3] = '{1'b0, 1'b0, 8'hFF, 8'h81, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1};
    vtab[4] = '{1'b0, 1'b1, 8'h12, 8'h7E, 1'b1, 8'h7E, 1'b1, 1'b1, 1'b0};

    ulpi_if.ulpi_dir_i     = 1'b0;
    ulpi_if.ulpi_nxt_i     = 1'b0;
    ulpi_if.ulpi_data_in_i = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst state", 32'(state_o), 32'd0);
    chk("rst phy_rst", 32'(ulpi_reset_o), 32'd1);
    chk("rst core_rst", 32'(core_rst_o), 32'd1);
    chk("rst ready", 32'(ready_o), 32'd0);
    chk("rst timeout", 32'(timeout_o), 32'd0);
    chk("rst turnaround", 32'(turnaround_o), 32'd0);
    chk("rst oe", 32'(ulpi_if.ulpi_data_oe_o), 32'd0);
    chk("rst data_out", 32'(ulpi_if.ulpi_data_out_o), 32'h00);

    powerup_seq("pwr1");

    // Table-driven RUN-mode bus vectors
    for (int i = 0; i < 5; i++) begin
      ulpi_if.ulpi_dir_i     = vtab[i].dir;
      ulpi_if.ulpi_nxt_i     = vtab[i].nxt;
      ulpi_if.ulpi_data_in_i = vtab[i].din;
      core_data_in_i         = vtab[i].cdat;
      core_stp_i             = vtab[i].cstp;
      #1;
      $display("vec %0d: dir=%0b data_out=%02h oe=%0b stp=%0b ta=%0b", i, vtab[i].dir,
               ulpi_if.ulpi_data_out_o, ulpi_if.ulpi_data_oe_o, ulpi_if.ulpi_stp_o, turnaround_o);
      chk($sformatf("vec%0d data_out", i), 32'(ulpi_if.ulpi_data_out_o), 32'(vtab[i].e_out));
      chk($sformatf("vec%0d oe", i), 32'(ulpi_if.ulpi_data_oe_o), 32'(vtab[i].e_oe));
      chk($sformatf("vec%0d stp", i), 32'(ulpi_if.ulpi_stp_o), 32'(vtab[i].e_stp));
      chk($sformatf("vec%0d turnaround", i), 32'(turnaround_o), 32'(vtab[i].e_ta));
      chk($sformatf("vec%0d core_data", i), 32'(core_data_out_o), 32'(vtab[i].din));
      chk($sformatf("vec%0d core_dir", i), 32'(core_dir_o), 32'(vtab[i].dir));
      chk($sformatf("vec%0d core_nxt", i), 32'(core_nxt_o), 32'(vtab[i].nxt));
      chk($sformatf("vec%0d state", i), 32'(state_o), 32'd3);
      tick();
    end
    ulpi_if.ulpi_dir_i = 1'b0;
    ulpi_if.ulpi_nxt_i = 1'b0;
    core_stp_i         = 1'b0;
    tick();

    // Soft re-sequence from RUN; a second request inside RESET must be ignored;
    // DIR held high through WAIT_DIR for 200 cycles.
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    ulpi_if.ulpi_dir_i = 1'b1;
    chk("soft state r1", 32'(state_o), 32'd0);
    chk("soft core_rst r1", 32'(core_rst_o), 32'd1);
    chk("soft phy_rst r1", 32'(ulpi_reset_o), 32'd1);
    chk("soft oe r1", 32'(ulpi_if.ulpi_data_oe_o), 32'd0);
    for (int r = 2; r <= 280; r++) begin
      if (r == 5) soft_rst_req_i = 1'b1;
      tick();
      soft_rst_req_i = 1'b0;
      if (r == 16 || r == 17 || r == 80 || r == 81 || r == 280) begin
        chk($sformatf("soft state r%0d", r), 32'(state_o),
            (r <= 16) ? 32'd0 : ((r <= 80) ? 32'd1 : 32'd2));
        chk($sformatf("soft phy_rst r%0d", r), 32'(ulpi_reset_o), 32'(r <= 16));
        chk($sformatf("soft core_rst r%0d", r), 32'(core_rst_o), 32'd1);
      end
    end
    ulpi_if.ulpi_dir_i = 1'b0;
    tick();
    chk("wait_dir exit state", 32'(state_o), 32'd3);
    chk("wait_dir exit core_rst", 32'(core_rst_o), 32'd1);
    tick();
    chk("run core_rst", 32'(core_rst_o), 32'd0);
    chk("run ready", 32'(ready_o), 32'd1);

    // Async reset mid-SETTLE
    soft_rst_req_i = 1'b1;
    tick();
    soft_rst_req_i = 1'b0;
    repeat (29) tick();
    chk("mid settle state", 32'(state_o), 32'd1);
    chk("mid settle phy_rst", 32'(ulpi_reset_o), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("async state", 32'(state_o), 32'd0);
    chk("async phy_rst", 32'(ulpi_reset_o), 32'd1);
    chk("async core_rst", 32'(core_rst_o), 32'd1);
    tick();
    tick();
    powerup_seq("pwr2");

    // DIR held high in RUN
    ulpi_if.ulpi_dir_i = 1'b1;
    #1;
    chk("wd oe release", 32'(ulpi_if.ulpi_data_oe_o), 32'd0);
    for (int j = 1; j <= 12; j++) begin
      tick();
`ifdef ULPI_FE_DIR_WATCHDOG_EN
      chk($sformatf("wd timeout j%0d", j), 32'(timeout_o), 32'(j == 8));
      chk($sformatf("wd state j%0d", j), 32'(state_o), (j < 8) ? 32'd3 : 32'd0);
`else
      chk($sformatf("wd timeout j%0d", j), 32'(timeout_o), 32'd0);
      chk($sformatf("wd state j%0d", j), 32'(state_o), 32'd3);
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ulpi_phy_frontend.md
Name: ulpi_phy_frontend

Overview:
- Parametrised ULPI pad front-end and PHY power-up sequencer between the ULPI pins and the USB/UVC core.
- Replaces the fixed reset shift register and hard-tied PHY reset with a configurable synchroniser and a timed PHY-reset/settle sequence.
- Holds the core in reset until the PHY has released DIR, and supports a software-requested re-sequence.
- Gates the ULPI output enable and STP, and flags bus turnaround cycles for the core.

Parameters:
- RST_SYNC_STAGES, 4, flops in the rst_n deassertion synchroniser (min 2).
- PHY_RST_CYCLES, 16, clk_i cycles ulpi_reset_o is held asserted.
- PHY_SETTLE_CYCLES, 64, cycles to wait after PHY reset release before sampling DIR.
- PHY_RST_ACTIVE_LOW, 0, 1: ulpi_reset_o is asserted low; 0: asserted high.
- DIR_TIMEOUT, 1024, max consecutive DIR-high cycles in RUN (watchdog only).

Ports:
- clk_i  in  1  60 MHz ULPI clock
- rst_n  in  1  asynchronous active-low reset
- soft_rst_req_i  in  1  one-cycle request to re-run the PHY sequence
- ulpi_dir_i  in  1  PHY DIR pin
- ulpi_nxt_i  in  1  PHY NXT pin
- ulpi_data_in_i  in  8  ULPI data pad input
- ulpi_data_out_o  out  8  ULPI data pad output
- ulpi_data_oe_o  out  1  pad output enable, 1 = link drives the bus
- ulpi_stp_o  out  1  STP pin
- ulpi_reset_o  out  1  PHY reset, polarity per PHY_RST_ACTIVE_LOW
- core_data_in_i  in  8  data from core to PHY
- core_stp_i  in  1  STP from core
- core_data_out_o  out  8  data to core (= ulpi_data_in_i)
- core_dir_o  out  1  DIR to core
- core_nxt_o  out  1  NXT to core
- core_rst_o  out  1  active-high synchronous reset to core
- turnaround_o  out  1  1 on any cycle where DIR differs from its previous sampled value
- ready_o  out  1  1 in RUN
- state_o  out  2  0 RESET, 1 SETTLE, 2 WAIT_DIR, 3 RUN
- timeout_o  out  1  one-cycle watchdog pulse (0 when watchdog is compiled out)

Behaviour:
- Clock and reset:
  - Single clock clk_i. Reset rst_n is asynchronous and active-low.
  - Internal reset asserts immediately on rst_n low.
  - Internal reset deasserts RST_SYNC_STAGES clk_i edges after rst_n rises.
- Values while internal reset is asserted:
  - state = RESET, counter = 0.
  - ulpi_reset_o asserted. core_rst_o = 1, ready_o = 0, timeout_o = 0, turnaround_o = 0.
  - dir_q = 1.
- Counter:
  - One shared down-counter, width $clog2 of the largest parameter plus 1.
  - Loaded on every state entry.
- RESET:
  - ulpi_reset_o asserted.
  - Leave to SETTLE after exactly PHY_RST_CYCLES cycles in RESET.
- SETTLE:
  - ulpi_reset_o deasserted.
  - Leave to WAIT_DIR after PHY_SETTLE_CYCLES cycles.
- WAIT_DIR:
  - Move to RUN on the first cycle DIR is sampled 0.
  - No timeout in this state.
- RUN:
  - core_rst_o = 0 from the cycle after entry; ready_o = 1.
  - core_rst_o and ready_o are registered from state.
- Outside RUN:
  - core_rst_o = 1.
  - ulpi_data_oe_o = 0, ulpi_stp_o = 0, ulpi_data_out_o = 8'h00.
- Inside RUN:
  - ulpi_data_oe_o = ~ulpi_dir_i, combinational; no registered delay is allowed on bus release.
  - ulpi_data_out_o = core_data_in_i.
  - ulpi_stp_o = core_stp_i.
- core_data_out_o, core_dir_o, core_nxt_o are combinational pass-through in all states.
- turnaround_o = ulpi_dir_i ^ dir_q. dir_q is the registered DIR, updated every cycle.
- soft_rst_req_i:
  - In any state except RESET: next state = RESET, counter reloaded, core_rst_o = 1 on the next cycle.
  - In RESET: ignored; the counter is not restarted.
- Simultaneous events: soft_rst_req_i takes priority over the RUN entry condition and over the watchdog.
- rst_n asserted mid-sequence: return to RESET asynchronously. The full sequence reruns after deassertion.

Optional Feature:
- Macro: ULPI_FE_DIR_WATCHDOG_EN.
- When defined, in RUN:
  - A counter counts consecutive cycles with DIR = 1; it clears when DIR = 0.
  - On reaching DIR_TIMEOUT: timeout_o pulses for 1 cycle and state goes to RESET, re-running the full sequence.
- When undefined: no watchdog logic is built and timeout_o is tied to 0.

Test Plan:
- Use RST_SYNC_STAGES=4, PHY_RST_CYCLES=16, PHY_SETTLE_CYCLES=64, DIR held 0. Release rst_n at cycle 0:
  - ulpi_reset_o asserted for cycles 4..19.
  - state_o = 1 for 64 cycles.
  - state_o = 2 then 3.
  - core_rst_o falls exactly one cycle after state_o = 3.
- Hold DIR = 1 for 200 cycles after SETTLE -> state_o stays 2, core_rst_o stays 1. DIR drops -> RUN on the next edge.
- In RUN, core_data_in_i = 8'hA5, core_stp_i = 1, DIR = 0 -> ulpi_data_out_o = 8'hA5, oe = 1, stp = 1.
- Raise DIR -> oe = 0 in the same cycle and turnaround_o = 1 for exactly one cycle.
- In RUN, pulse soft_rst_req_i for 1 cycle -> state_o = 0, core_rst_o = 1 and ulpi_reset_o asserted next cycle, then the full 16 + 64 sequence.
- Assert rst_n low mid-SETTLE -> state_o = 0 and ulpi_reset_o asserted without waiting for a clock edge.
- With ULPI_FE_DIR_WATCHDOG_EN and DIR_TIMEOUT = 8:
  - In RUN, hold DIR = 1 -> timeout_o pulses on cycle 8 and state_o = 0.
  - Without the macro, the same stimulus -> timeout_o = 0 and state stays RUN.
